// File: rtl/cronometro_contador.sv
// Stopwatch time base: divides clk into 0.1 s ticks and counts tenths (0-9) and seconds (0..SEG_MAX) in binary.
// Define CRONOMETRO_VOLTA_EN to add the btn_volta lap-hold feature.
module cronometro_contador #(
    parameter int unsigned DIV_DECIMO = 5000000,
    parameter int unsigned SEG_MAX    = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inicia_para,
    input  logic       btn_zera,
`ifdef CRONOMETRO_VOLTA_EN
    input  logic       btn_volta,
`endif
    output logic [9:0] cont_seg,
    output logic [3:0] cont_dec,
    output logic       rodando,
    output logic       estouro
);
    localparam int unsigned SW = 10;
    localparam int unsigned DW = 4;
    localparam int unsigned PW = (DIV_DECIMO > 1) ? $clog2(DIV_DECIMO) : 1;

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] seg_q, seg_d, out_seg_d;
    logic [DW-1:0] dec_q, dec_d, out_dec_d;
    logic          ip_q, z_q;
    logic          pulso_ip, pulso_z, tick, wrap;

`ifdef CRONOMETRO_VOLTA_EN
    logic          volta_q, pulso_volta;
    logic          hold_q, hold_d;
    logic [SW-1:0] snap_seg_q, snap_seg_d;
    logic [DW-1:0] snap_dec_q, snap_dec_d;
`endif

    // Next-state, prescaler and counter logic
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        seg_d     = seg_q;
        dec_d     = dec_q;
        wrap      = 1'b0;
        pulso_ip  = btn_inicia_para & ~ip_q;
        pulso_z   = btn_zera & ~z_q;
        tick      = (state_q == CONTANDO) && (presc_q == PW'(DIV_DECIMO - 1));

        if (pulso_ip) begin
            if (state_q == PARADO) state_d = CONTANDO;
            else                   state_d = PARADO;
        end

        // Prescaler holds in PARADO so a pause keeps the partial tenth
        if (state_q == CONTANDO) begin
            if (tick) presc_d = '0;
            else      presc_d = presc_q + PW'(1);
        end

        if (tick) begin
            if (dec_q == DW'(9)) begin
                dec_d = '0;
                if (seg_q == SW'(SEG_MAX)) begin
                    seg_d = '0;
                    wrap  = 1'b1;
                end else begin
                    seg_d = seg_q + SW'(1);
                end
            end else begin
                dec_d = dec_q + DW'(1);
            end
        end

        // Clear discards any tick in the same cycle
        if (pulso_z) begin
            seg_d   = '0;
            dec_d   = '0;
            presc_d = '0;
            wrap    = 1'b0;
        end

`ifdef CRONOMETRO_VOLTA_EN
        pulso_volta = btn_volta & ~volta_q;
        hold_d      = hold_q;
        snap_seg_d  = snap_seg_q;
        snap_dec_d  = snap_dec_q;
        if (pulso_volta) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                snap_seg_d = seg_q;
                snap_dec_d = dec_q;
            end
        end
        if (pulso_z) hold_d = 1'b0;
        out_seg_d = hold_d ? snap_seg_d : seg_d;
        out_dec_d = hold_d ? snap_dec_d : dec_d;
`else
        out_seg_d = seg_d;
        out_dec_d = dec_d;
`endif
    end

    // State, counters, edge-detect and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PARADO;
            presc_q  <= '0;
            seg_q    <= '0;
            dec_q    <= '0;
            ip_q     <= 1'b0;
            z_q      <= 1'b0;
            cont_seg <= '0;
            cont_dec <= '0;
            rodando  <= 1'b0;
            estouro  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            seg_q    <= seg_d;
            dec_q    <= dec_d;
            ip_q     <= btn_inicia_para;
            z_q      <= btn_zera;
            cont_seg <= out_seg_d;
            cont_dec <= out_dec_d;
            rodando  <= (state_d == CONTANDO);
            estouro  <= wrap;
        end
    end

`ifdef CRONOMETRO_VOLTA_EN
    // Lap-hold flag and snapshot of the displayed counts
    always_ff @(posedge clk) begin
        if (reset) begin
            volta_q    <= 1'b0;
            hold_q     <= 1'b0;
            snap_seg_q <= '0;
            snap_dec_q <= '0;
        end else begin
            volta_q    <= btn_volta;
            hold_q     <= hold_d;
            snap_seg_q <= snap_seg_d;
            snap_dec_q <= snap_dec_d;
        end
    end
`endif

endmodule

// File: tb/tb_cronometro_contador.sv
// Scoreboard bench for cronometro_contador (DIV_DECIMO=4); a second instance with SEG_MAX=2 covers the full wrap.
// The lap-hold scenario runs only when CRONOMETRO_VOLTA_EN is defined.
module tb_cronometro_contador;
    localparam int DIV = 4;

    typedef struct packed {
        logic [9:0] seg;
        logic [3:0] dec;
        logic       run;
        logic       ov;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ip = 1'b1;
    logic       z = 1'b1;
`ifdef CRONOMETRO_VOLTA_EN
    logic       volta = 1'b0;
`endif
    logic [9:0] seg_a, seg_b;
    logic [3:0] dec_a, dec_b;
    logic       run_a, run_b, ov_a, ov_b;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cronometro_contador #(.DIV_DECIMO(DIV), .SEG_MAX(999)) dut (
        .clk(clk), .reset(reset), .btn_inicia_para(ip), .btn_zera(z),
`ifdef CRONOMETRO_VOLTA_EN
        .btn_volta(volta),
`endif
        .cont_seg(seg_a), .cont_dec(dec_a), .rodando(run_a), .estouro(ov_a)
    );

    cronometro_contador #(.DIV_DECIMO(DIV), .SEG_MAX(2)) dut_wrap (
        .clk(clk), .reset(reset), .btn_inicia_para(ip), .btn_zera(z),
`ifdef CRONOMETRO_VOLTA_EN
        .btn_volta(volta),
`endif
        .cont_seg(seg_b), .cont_dec(dec_b), .rodando(run_b), .estouro(ov_b)
    );

    function automatic obs_t mk(int s, int d, logic r, logic o);
        obs_t x;
        x.seg = 10'(s);
        x.dec = 4'(d);
        x.run = r;
        x.ov  = o;
        return x;
    endfunction

    // Expected outputs k edges after a start edge, given tenths already counted and the prescaler at that edge
    function automatic obs_t exp_at(int base, int p0, int k, logic run, int segmax);
        int t, tp, per;
        per = 10 * (segmax + 1);
        t   = base + (p0 + k) / DIV;
        tp  = (k > 0) ? base + (p0 + k - 1) / DIV : t;
        return mk((t / 10) % (segmax + 1), t % 10, run, (t != tp) && (t % per == 0));
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        ip = 1'b0;
        z = 1'b0;
`ifdef CRONOMETRO_VOLTA_EN
        volta = 1'b0;
`endif
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_held[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        ip = 1'b0;
        z = 1'b0;
    endtask

    task automatic test_count();
        obs_t e, o;
        apply_reset();
        ip = 1'b1;
        for (int k = 0; k <= 41; k++) begin
            exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL count[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        ip = 1'b0;
    endtask

    task automatic test_pause();
        obs_t e, o;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            ip = (k == 0 || k == 6 || k == 27) ? 1'b1 : 1'b0;
            if (k <= 5)       exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            else if (k == 6)  exp_q.push_back(exp_at(0, 0, k, 1'b0, 999));
            else if (k < 27)  exp_q.push_back(mk(0, 1, 1'b0, 1'b0));
            else              exp_q.push_back(exp_at(1, 2, k - 27, 1'b1, 999));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pause[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        ip = 1'b0;
    endtask

    task automatic test_pause_on_tick();
        obs_t e, o;
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            ip = (k == 0 || k == 4) ? 1'b1 : 1'b0;
            if (k < 4)       exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            else             exp_q.push_back(mk(0, 1, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pause_tick[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        ip = 1'b0;
    endtask

    task automatic test_wrap();
        obs_t e, o;
        apply_reset();
        for (int k = 0; k <= 124; k++) begin
            ip = (k == 0) ? 1'b1 : 1'b0;
            exp_q.push_back(exp_at(0, 0, k, 1'b1, 2));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_b, dec_b, run_b, ov_b};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL wrap[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
    endtask

    task automatic test_clear();
        obs_t e, o;
        apply_reset();
        // k=64: clear+stop on the 1.5->1.6 tick; k=70..73 run/pause to prescaler 3; k=74 clear while paused;
        // k=75 restart from prescaler 0; k=81 clear while running off-tick
        for (int k = 0; k <= 86; k++) begin
            ip = (k == 0 || k == 64 || k == 70 || k == 73 || k == 75) ? 1'b1 : 1'b0;
            z  = (k == 64 || k == 74 || k == 81) ? 1'b1 : 1'b0;
            if (k < 64)       exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            else if (k < 70)  exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
            else if (k < 73)  exp_q.push_back(exp_at(0, 0, k - 70, 1'b1, 999));
            else if (k < 75)  exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
            else if (k < 81)  exp_q.push_back(exp_at(0, 0, k - 75, 1'b1, 999));
            else              exp_q.push_back(exp_at(0, 0, k - 81, 1'b1, 999));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clear[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        ip = 1'b0;
        z = 1'b0;
    endtask

`ifdef CRONOMETRO_VOLTA_EN
    task automatic test_volta();
        obs_t e, o;
        apply_reset();
        for (int k = 0; k <= 43; k++) begin
            ip    = (k == 0) ? 1'b1 : 1'b0;
            volta = (k == 13 || k == 33 || k == 37) ? 1'b1 : 1'b0;
            z     = (k == 38) ? 1'b1 : 1'b0;
            if (k < 13)       exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            else if (k < 33)  exp_q.push_back(mk(0, 3, 1'b1, 1'b0));
            else if (k < 37)  exp_q.push_back(exp_at(0, 0, k, 1'b1, 999));
            else if (k == 37) exp_q.push_back(mk(0, 9, 1'b1, 1'b0));
            else              exp_q.push_back(exp_at(0, 0, k - 38, 1'b1, 999));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {seg_a, dec_a, run_a, ov_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL volta[%0d]: got %0d.%0d run=%0b ov=%0b want %0d.%0d run=%0b ov=%0b", k, o.seg, o.dec, o.run, o.ov, e.seg, e.dec, e.run, e.ov);
            end
        end
        volta = 1'b0;
        z = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_pause_on_tick();
        test_wrap();
        test_clear();
`ifdef CRONOMETRO_VOLTA_EN
        test_volta();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cronometro_contador.md
Name: cronometro_contador

Overview:
Stopwatch time base and counter stage.
- Divides clk down to 0.1 s ticks.
- Counts tenths (0-9) and seconds (0..SEG_MAX).
- Runs and pauses under a start/stop button; clears under a zero button.
- Outputs are binary, not BCD, and feed the seven-segment decoder stage directly downstream, which splits seconds into hundreds/tens/units and decodes tenths.

Parameters:
- DIV_DECIMO, 5000000: clk cycles per 0.1 s tick (50 MHz board clock); must be >= 2.
- SEG_MAX, 999: largest seconds value before wrap; must be <= 1023.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- btn_inicia_para  in  1  start/stop button level; already debounced and synchronous to clk.
- btn_zera  in  1  clear button level; already debounced and synchronous to clk.
- cont_seg  out  10  seconds count, binary, 0..SEG_MAX.
- cont_dec  out  4  tenths count, binary, 0..9.
- rodando  out  1  high while in state CONTANDO.
- estouro  out  1  one-cycle pulse on full wrap SEG_MAX.9 -> 0.0.

Behaviour:
- Reset (clk edge with reset=1):
  - cont_seg=0, cont_dec=0, estouro=0, rodando=0.
  - State PARADO, prescaler=0.
  - Both edge-detect registers loaded with 0.
  - Reset overrides every other input.
- Edge detect:
  - pulso_ip = btn_inicia_para & ~btn_inicia_para_q; pulso_z = btn_zera & ~btn_zera_q.
  - Both _q registers are updated every cycle.
  - A held button produces exactly one pulse.
  - A button already high when reset releases pulses in the first cycle after reset.
- State machine, two states:
  - PARADO --pulso_ip--> CONTANDO.
  - CONTANDO --pulso_ip--> PARADO.
  - rodando = (state==CONTANDO), registered with the state.
- Prescaler, width clog2(DIV_DECIMO):
  - Increments only in CONTANDO.
  - Held, not cleared, in PARADO, so pause/resume preserves the partial tenth.
  - tick = CONTANDO & prescaler==DIV_DECIMO-1; on tick the prescaler goes to 0.
- Counting on tick:
  - cont_dec<9: cont_dec+1.
  - cont_dec==9: cont_dec=0 and cont_seg+1.
  - cont_dec==9 and cont_seg==SEG_MAX: both go to 0 and estouro=1 for exactly that next cycle.
  - State stays CONTANDO after a wrap.
- Latency:
  - pulso_ip seen in cycle N; state is CONTANDO from edge N.
  - First tenth increment is visible after edge N+DIV_DECIMO.
  - Outputs are registered; no combinational path from inputs to outputs.
- Clear (pulso_z):
  - cont_seg, cont_dec and prescaler go to 0 at that edge, in either state.
  - Any tick in the same cycle is discarded.
  - estouro=0 that cycle.
- Simultaneous pulso_z and pulso_ip: counts clear and the state still toggles.
- Pause/tick collision: pulso_ip in the same cycle as a tick in CONTANDO means the tick is applied, then the state goes PARADO.
- Invariants: cont_dec never exceeds 9 and cont_seg never exceeds SEG_MAX in any reachable state.

Optional Feature:
- Macro CRONOMETRO_VOLTA_EN (lap hold).
- Defined:
  - Adds input btn_volta (1 bit, debounced, synchronous), with the same edge detect.
  - Each pulso_volta toggles a hold flag; entering hold snapshots the live counts.
  - While hold=1, cont_seg/cont_dec show the snapshot and internal counting continues.
  - hold is cleared by reset, or by pulso_z, which also makes the outputs show 0.0.
  - estouro always reflects the internal wrap.
- Undefined: port btn_volta is absent and outputs always show live counts.

Test Plan (DIV_DECIMO=4, SEG_MAX=999 unless noted):
1. Reset with both buttons high for 2 cycles, then release reset -> cont_seg=0, cont_dec=0, rodando=0; with buttons held, exactly one start pulse occurs, then rodando=1.
2. Start pulse, then run 40 cycles -> cont_dec cycles 1..9, then cont_seg=1, cont_dec=0 exactly 40 cycles after the start edge; the button held high the whole time never stops the count.
3. Start, wait 6 cycles (1 tick + 2 partial), stop, idle 20 cycles, restart -> counts frozen at 0.1 during pause; the next increment (0.2) arrives 2 cycles after restart.
4. SEG_MAX=2: run 30 ticks -> sequence reaches 2.9 then 0.0; estouro high for exactly one cycle coincident with 0.0; rodando stays 1.
5. Counting at 1.5, assert btn_zera on the tick cycle together with btn_inicia_para -> counts=0.0, prescaler 0, rodando=0, estouro=0.
6. CRONOMETRO_VOLTA_EN: at 0.3 press btn_volta -> outputs hold 0.3 for 20 cycles while internal reaches 0.8; press again -> outputs show 0.8 live; btn_zera during hold -> 0.0 and hold cleared.
